// File: rtl/isp_bnr_pkg.sv
// Shared constants and types for the adaptive Bayer noise-reduction block.
// Holds pipeline depth, Gaussian weights, Bayer codes and the colour helper.
package isp_bnr_pkg;

    localparam int DLY_CLK    = 9;
    // Window load plus S1..S5; the remainder is taken up by an input delay.
    localparam int WIN_STAGES = 6;
    localparam int IN_DLY     = DLY_CLK - WIN_STAGES;

    localparam int W_RB_CTR    = 4;
    localparam int W_RB_CROSS  = 2;
    localparam int W_RB_CORNER = 1;
    localparam int W_G_CTR     = 4;
    localparam int W_G_DIAG    = 2;
    localparam int W_G_CROSS   = 1;

    localparam logic [1:0] BAYER_RGGB = 2'd0;
    localparam logic [1:0] BAYER_GRBG = 2'd1;
    localparam logic [1:0] BAYER_GBRG = 2'd2;
    localparam logic [1:0] BAYER_BGGR = 2'd3;

    localparam logic [4:0] STRENGTH_MAX = 5'd16;

    typedef enum logic [1:0] {
        CLR_R  = 2'd0,
        CLR_GR = 2'd1,
        CLR_GB = 2'd2,
        CLR_B  = 2'd3
    } colour_t;

    typedef struct packed {
        logic href;
        logic vsync;
        logic de;
    } sync_t;

    function automatic colour_t centre_colour(input logic [1:0] bayer,
                                              input logic rp,
                                              input logic cp);
        colour_t base;
        unique case (bayer)
            BAYER_RGGB: base = CLR_R;
            BAYER_GRBG: base = CLR_GR;
            BAYER_GBRG: base = CLR_GB;
            BAYER_BGGR: base = CLR_B;
            default:    base = CLR_R;
        endcase
        return colour_t'(base ^ {rp, cp});
    endfunction

    function automatic logic is_green(input colour_t c);
        return (c == CLR_GR) || (c == CLR_GB);
    endfunction

endpackage

// File: rtl/isp_bnr_linebuf.sv
// Four-line same-column history for the 5x5 window; RAM is never cleared.
// Ports: pclk, shift (write enable), col (address), din, tap[0..3] = rows n-1..n-4.
module isp_bnr_linebuf
    import isp_bnr_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int WIDTH = 1280,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic                 pclk,
    input  logic                 shift,
    input  logic [CW-1:0]        col,
    input  logic [BITS-1:0]      din,
    output logic [3:0][BITS-1:0] tap
);

    logic [BITS-1:0] mem [4][WIDTH];

    always_ff @(posedge pclk) begin
        if (shift) begin
            mem[0][col] <= din;
            for (int i = 1; i < 4; i++)
                mem[i][col] <= mem[i-1][col];
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++)
            tap[i] = mem[i][col];
    end

endmodule

// File: rtl/isp_bnr_adaptive.sv
// Edge-preserving Bayer NR: 5x5 same-colour Gaussian with threshold exclusion and strength blend.
// Ports: pclk, rst_n (sync, active-low), bayer, nr_thresh, nr_strength, in_href/in_vsync/in_de/in_raw,
// out_href/out_vsync/out_de/out_raw (DLY_CLK later). Macro ISP_BNR_EDGE_CLAMP_EN excludes off-frame taps.
module isp_bnr_adaptive
    import isp_bnr_pkg::*;
#(
    parameter int BITS   = 8,
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 960
) (
    input  logic            pclk,
    input  logic            rst_n,
    input  logic [1:0]      bayer,
    input  logic [BITS-1:0] nr_thresh,
    input  logic [4:0]      nr_strength,
    input  logic            in_href,
    input  logic            in_vsync,
    input  logic            in_de,
    input  logic [BITS-1:0] in_raw,
    output logic            out_href,
    output logic            out_vsync,
    output logic            out_de,
    output logic [BITS-1:0] out_raw
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int SW = BITS + 4;
    localparam int PW = BITS + 6;

    logic [1:0]      sh_bayer;
    logic [BITS-1:0] sh_thresh;
    logic [4:0]      sh_str;

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            sh_bayer  <= BAYER_RGGB;
            sh_thresh <= '0;
            sh_str    <= '0;
        end else if (in_vsync) begin
            sh_bayer  <= bayer;
            sh_thresh <= nr_thresh;
            sh_str    <= (nr_strength > STRENGTH_MAX) ? STRENGTH_MAX : nr_strength;
        end
    end

    sync_t           sd [DLY_CLK];
    logic [BITS-1:0] rd [IN_DLY];

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            for (int i = 0; i < DLY_CLK; i++) sd[i] <= '0;
            for (int i = 0; i < IN_DLY; i++)  rd[i] <= '0;
        end else begin
            sd[0] <= '{in_href, in_vsync, in_de};
            for (int i = 1; i < DLY_CLK; i++) sd[i] <= sd[i-1];
            rd[0] <= in_raw;
            for (int i = 1; i < IN_DLY; i++)  rd[i] <= rd[i-1];
        end
    end

    assign out_href  = sd[DLY_CLK-1].href;
    assign out_vsync = sd[DLY_CLK-1].vsync;
    assign out_de    = sd[DLY_CLK-1].de;

    logic            h, v, href_q;
    logic [BITS-1:0] px;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;

    assign h  = sd[IN_DLY-1].href;
    assign v  = sd[IN_DLY-1].vsync;
    assign px = rd[IN_DLY-1];

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            href_q <= 1'b0;
            col    <= '0;
            row    <= '0;
        end else begin
            href_q <= h;
            if (h)
                col <= (col == CW'(WIDTH - 1)) ? col : col + 1'b1;
            else
                col <= '0;
            if (v)
                row <= '0;
            else if (href_q && !h && row != RW'(HEIGHT - 1))
                row <= row + 1'b1;
        end
    end

    logic [3:0][BITS-1:0] lb_tap;

    isp_bnr_linebuf #(.BITS(BITS), .WIDTH(WIDTH), .CW(CW)) u_linebuf (
        .pclk  (pclk),
        .shift (h),
        .col   (col),
        .din   (px),
        .tap   (lb_tap)
    );

    // win[r][c]: row 0 is the oldest line, column 4 the newest sample.
    logic [BITS-1:0] win [5][5];
    logic            w_valid, w_green;
`ifdef ISP_BNR_EDGE_CLAMP_EN
    logic            w_r0, w_r1, w_c0, w_c1;
`endif

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    win[r][c] <= '0;
            w_valid <= 1'b0;
            w_green <= 1'b0;
`ifdef ISP_BNR_EDGE_CLAMP_EN
            w_r0 <= 1'b0; w_r1 <= 1'b0;
            w_c0 <= 1'b0; w_c1 <= 1'b0;
`endif
        end else begin
            w_valid <= h && row >= RW'(2) && col >= CW'(2);
            if (h) begin
                for (int r = 0; r < 5; r++)
                    for (int c = 0; c < 4; c++)
                        win[r][c] <= win[r][c+1];
                win[4][4] <= px;
                for (int r = 0; r < 4; r++)
                    win[r][4] <= lb_tap[3-r];
                w_green <= is_green(centre_colour(sh_bayer, row[0], col[0]));
`ifdef ISP_BNR_EDGE_CLAMP_EN
                w_r0 <= (row == RW'(2)); w_r1 <= (row == RW'(3));
                w_c0 <= (col == CW'(2)); w_c1 <= (col == CW'(3));
`endif
            end
        end
    end

    // Taps 0..3 cross (0,+-2)/(+-2,0), 4..7 corners (+-2,+-2), 8..11 diagonals (+-1,+-1).
    logic [BITS-1:0] tap [12];
    logic [11:0]     oob;

    always_comb begin
        tap[0]  = win[2][0]; tap[1]  = win[2][4];
        tap[2]  = win[0][2]; tap[3]  = win[4][2];
        tap[4]  = win[0][0]; tap[5]  = win[0][4];
        tap[6]  = win[4][0]; tap[7]  = win[4][4];
        tap[8]  = win[1][1]; tap[9]  = win[1][3];
        tap[10] = win[3][1]; tap[11] = win[3][3];
        oob = '0;
`ifdef ISP_BNR_EDGE_CLAMP_EN
        oob[0]  = w_c0 | w_c1;
        oob[2]  = w_r0 | w_r1;
        oob[4]  = w_r0 | w_r1 | w_c0 | w_c1;
        oob[5]  = w_r0 | w_r1;
        oob[6]  = w_c0 | w_c1;
        oob[8]  = w_r0 | w_c0;
        oob[9]  = w_r0;
        oob[10] = w_c0;
`endif
    end

    function automatic logic [BITS-1:0] absd(input logic [BITS-1:0] a,
                                             input logic [BITS-1:0] b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic logic [BITS+1:0] sum4(input logic [BITS-1:0] a, b, c, d);
        return {2'b0, a} + {2'b0, b} + {2'b0, c} + {2'b0, d};
    endfunction

    logic [BITS-1:0] s1_tap [12];
    logic [BITS-1:0] s1_c, s2_c, s3_c, s4_c, s3_f, res;
    logic [BITS+1:0] s2_cross, s2_corner, s2_diag;
    logic            s1_green, s2_green;
    logic            s1_valid, s2_valid, s3_valid, s4_valid;
    logic [SW-1:0]   tot;
    logic signed [PW-1:0] dx, sx, prod, s4_prod, blend;

    always_comb begin
        tot = s2_green
            ? SW'(W_G_CTR * s2_c + W_G_DIAG * s2_diag + W_G_CROSS * s2_cross)
            : SW'(W_RB_CTR * s2_c + W_RB_CROSS * s2_cross + W_RB_CORNER * s2_corner);
        dx    = PW'($signed({1'b0, s3_f}) - $signed({1'b0, s3_c}));
        sx    = PW'($signed({1'b0, sh_str}));
        prod  = dx * sx;
        blend = PW'($signed({1'b0, s4_c})) + (s4_prod >>> 4);
        if (blend[PW-1])
            res = '0;
        else if (|blend[PW-2:BITS])
            res = '1;
        else
            res = blend[BITS-1:0];
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            for (int i = 0; i < 12; i++) s1_tap[i] <= '0;
            {s1_c, s2_c, s3_c, s4_c, s3_f} <= '0;
            {s2_cross, s2_corner, s2_diag} <= '0;
            {s1_green, s2_green} <= '0;
            {s1_valid, s2_valid, s3_valid, s4_valid} <= '0;
            s4_prod <= '0;
            out_raw <= '0;
        end else begin
            for (int i = 0; i < 12; i++)
                s1_tap[i] <= (absd(tap[i], win[2][2]) > sh_thresh || oob[i])
                             ? win[2][2] : tap[i];
            s1_c      <= win[2][2];
            s1_green  <= w_green;
            s1_valid  <= w_valid;
            s2_cross  <= sum4(s1_tap[0], s1_tap[1], s1_tap[2], s1_tap[3]);
            s2_corner <= sum4(s1_tap[4], s1_tap[5], s1_tap[6], s1_tap[7]);
            s2_diag   <= sum4(s1_tap[8], s1_tap[9], s1_tap[10], s1_tap[11]);
            s2_c      <= s1_c;
            s2_green  <= s1_green;
            s2_valid  <= s1_valid;
            s3_f      <= BITS'(tot >> 4);
            s3_c      <= s2_c;
            s3_valid  <= s2_valid;
            s4_prod   <= prod;
            s4_c      <= s3_c;
            s4_valid  <= s3_valid;
            out_raw   <= (sd[DLY_CLK-2].href && s4_valid) ? res : '0;
        end
    end

endmodule

// File: tb/tb_isp_bnr_adaptive.sv
// Directed bench for isp_bnr_adaptive: flat, hot-pixel, threshold, strength, bayer and reset cases.
// Captures each output frame by out_href position and compares against hand-computed values.
module tb_isp_bnr_adaptive;

    localparam int BITS   = 8;
    localparam int WIDTH  = 16;
    localparam int HEIGHT = 8;
    localparam int HBLANK = 12;

    logic            pclk        = 1'b0;
    logic            rst_n       = 1'b0;
    logic [1:0]      bayer       = 2'd0;
    logic [BITS-1:0] nr_thresh   = 8'd255;
    logic [4:0]      nr_strength = 5'd16;
    logic            in_href     = 1'b0;
    logic            in_vsync    = 1'b0;
    logic            in_de       = 1'b0;
    logic [BITS-1:0] in_raw      = '0;
    logic            out_href, out_vsync, out_de;
    logic [BITS-1:0] out_raw;

    int total = 0;
    int bad   = 0;
    int img [HEIGHT][WIDTH];
    int cap [HEIGHT][WIDTH];
    logic [2:0] hist [9];
    int   orow = 0;
    int   ocol = 0;
    logic oh_q = 1'b0;

    always #5 pclk = ~pclk;

    isp_bnr_adaptive #(.BITS(BITS), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .bayer       (bayer),
        .nr_thresh   (nr_thresh),
        .nr_strength (nr_strength),
        .in_href     (in_href),
        .in_vsync    (in_vsync),
        .in_de       (in_de),
        .in_raw      (in_raw),
        .out_href    (out_href),
        .out_vsync   (out_vsync),
        .out_de      (out_de),
        .out_raw     (out_raw)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 9; i++) hist[i] = '0;
        forever begin
            @(posedge pclk);
            if (!rst_n) begin
                for (int i = 0; i < 9; i++) hist[i] = '0;
            end else begin
                for (int i = 8; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = {in_href, in_vsync, in_de};
            end
            #1;
            check("sync_delay", int'({out_href, out_vsync, out_de}), int'(hist[8]));
            if (!out_href) check("blank_raw", int'(out_raw), 0);
            if (out_vsync) begin
                orow = 0;
                ocol = 0;
            end else if (out_href) begin
                if (orow < HEIGHT && ocol < WIDTH) cap[orow][ocol] = int'(out_raw);
                ocol++;
            end else begin
                if (oh_q) orow++;
                ocol = 0;
            end
            oh_q = out_href;
        end
    end

    task automatic tick(input logic hr, input logic vs, input int raw);
        @(negedge pclk);
        in_href  = hr;
        in_de    = hr;
        in_vsync = vs;
        in_raw   = BITS'(raw);
    endtask

    task automatic fill(input int base, input int hr, input int hc, input int hv);
        for (int r = 0; r < HEIGHT; r++)
            for (int c = 0; c < WIDTH; c++)
                img[r][c] = base;
        if (hr >= 0) img[hr][hc] = hv;
    endtask

    task automatic run_frame(input int mid_row, input int mid_s,
                             input int rst_row, input int rst_col);
        for (int r = 0; r < HEIGHT; r++)
            for (int c = 0; c < WIDTH; c++)
                cap[r][c] = -1;
        repeat (4) tick(1'b0, 1'b1, 0);
        repeat (2) tick(1'b0, 1'b0, 0);
        for (int r = 0; r < HEIGHT; r++) begin
            if (r == mid_row) nr_strength = 5'(mid_s);
            for (int c = 0; c < WIDTH; c++) begin
                tick(1'b1, 1'b0, img[r][c]);
                if (r == rst_row && c == rst_col) begin
                    rst_n = 1'b0;
                    @(posedge pclk);
                    #1;
                    check("rst_href",  int'(out_href),  0);
                    check("rst_vsync", int'(out_vsync), 0);
                    check("rst_de",    int'(out_de),    0);
                    check("rst_raw",   int'(out_raw),   0);
                    rst_n = 1'b1;
                end
            end
            repeat (HBLANK) tick(1'b0, 1'b0, 0);
        end
        repeat (8) tick(1'b0, 1'b0, 0);
    endtask

    function automatic int pix(input int r, input int c);
        return cap[r+2][c+2];
    endfunction

    task automatic check_img(input string tag);
        int exp;
        for (int r = 0; r < HEIGHT; r++)
            for (int c = 0; c < WIDTH; c++) begin
                exp = (r < 2 || c < 2) ? 0 : img[r-2][c-2];
                check($sformatf("%s[%0d][%0d]", tag, r, c), cap[r][c], exp);
            end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge pclk);
        @(posedge pclk);
        #1;
        check("init_href",  int'(out_href),  0);
        check("init_vsync", int'(out_vsync), 0);
        check("init_de",    int'(out_de),    0);
        check("init_raw",   int'(out_raw),   0);
        @(negedge pclk);
        rst_n = 1'b1;

        fill(100, -1, 0, 0);
        run_frame(-1, 0, -1, -1);
        run_frame(-1, 0, -1, -1);
        check_img("flat");

        fill(100, 4, 6, 200);
        run_frame(-1, 0, -1, -1);
        check("hot_s16", pix(4, 6), 125);
        check("nbr_s16", pix(4, 8), 112);

        bayer       = 2'd1;
        nr_strength = 5'd20;
        run_frame(-1, 0, -1, -1);
        check("g_hot",   pix(4, 6), 125);
        check("g_cross", pix(4, 8), 106);
        check("g_diag",  pix(5, 7), 112);

        bayer       = 2'd0;
        nr_strength = 5'd16;
        nr_thresh   = 8'd50;
        run_frame(-1, 0, -1, -1);
        check("thr_hot", pix(4, 6), 200);
        check("thr_nbr", pix(4, 8), 100);

        nr_thresh   = 8'd255;
        nr_strength = 5'd8;
        run_frame(-1, 0, -1, -1);
        check("s8_hot", pix(4, 6), 162);
        check("s8_nbr", pix(4, 8), 106);

        nr_strength = 5'd16;
        run_frame(1, 0, -1, -1);
        check("mid_hot", pix(4, 6), 125);
        check("mid_nbr", pix(4, 8), 112);
        run_frame(-1, 0, -1, -1);
        check_img("s0");

        nr_strength = 5'd16;
        fill(100, -1, 0, 0);
        run_frame(-1, 0, 3, 12);
        run_frame(-1, 0, -1, -1);
        check_img("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/isp_bnr_adaptive.md
# isp_bnr_adaptive

Edge-preserving Bayer-domain noise reduction that supersedes the fixed-level Gaussian BNR in the raw ISP chain, between the raw input/black-level stage and demosaic. It builds a 5x5 same-colour window per pixel and excludes neighbours that differ from the centre by more than a programmable threshold, so edges are not smeared. It then applies a fixed 16-weight Gaussian and blends the result with the original pixel using a programmable strength. Bayer order and controls are runtime inputs latched per frame.

## Interface
- BITS, 8, raw sample width
- WIDTH, 1280, active pixels per line; line-buffer depth
- HEIGHT, 960, active lines per frame; row-counter range
- pclk  in  1  pixel clock; the only clock
- rst_n  in  1  reset, synchronous, active-low
- bayer  in  2  0:RGGB 1:GRBG 2:GBRG 3:BGGR
- nr_thresh  in  BITS  max |tap−centre| for a tap to be used
- nr_strength  in  5  blend weight 0..16; values above 16 are treated as 16
- in_href, in_vsync, in_de  in  1  input syncs
- in_raw  in  BITS  raw sample, valid while in_href
- out_href, out_vsync, out_de  out  1  syncs delayed DLY_CLK
- out_raw  out  BITS  filtered sample; 0 when out_href is low

## Operation
- Controls: bayer, nr_thresh and nr_strength are latched into shadow registers on every pclk while in_vsync=1. Changes made mid-frame take effect from the next frame.
- Counters:
  - col increments per in_href sample and clears while in_href=0.
  - row increments on each in_href falling edge and clears while in_vsync=1.
  - Both counters saturate at WIDTH-1 and HEIGHT-1.
- Window: the 4-line buffer plus a 5x5 register array. The centre is input pixel (row−2, col−2).
- Centre colour = bayer ^ {row parity, col parity}, using the parities of the centre pixel.
- Taps and weights (each set sums to 16):
  - R/B: centre 4; (0,±2),(±2,0) weight 2 each; (±2,±2) weight 1 each.
  - Gr/Gb: centre 4; (±1,±1) weight 2 each; (0,±2),(±2,0) weight 1 each.
- Exclusion: any tap with |tap−c| > nr_thresh is replaced by c before weighting.
  - nr_thresh = 2^BITS−1 gives a pure Gaussian.
  - nr_thresh = 0 passes only taps equal to c.
- f = weighted sum >> 4. The sum is held in BITS+4 bits, so no overflow is possible.
- Blend: out = c + (((f−c) · s) >>> 4), where s is the clamped strength.
  - The difference is signed BITS+1; the product is BITS+6.
  - The shift is arithmetic (floor); the result is clamped to [0, 2^BITS−1].
- Output positions with out-row < 2 or out-col < 2 have no centre and output 0.

## Timing
- Pipeline stages after the window:
  - S1: abs-diff, compare, substitute.
  - S2: partial weighted sums.
  - S3: total and >>4.
  - S4: multiply.
  - S5: add, clamp.
- DLY_CLK = 9: out_href, out_vsync and out_de equal the corresponding inputs 9 cycles earlier.
- Output sample k of output line n (counted in out_href) carries the filtered input pixel (n−2, k−2).
- Throughput: one pixel per clock. There is no backpressure.
- Reset: all outputs and all registers, including the sync delay lines, counters and shadow registers, read 0 on the cycle after rst_n is sampled low.
  - Line-buffer RAM contents are not cleared.
  - A reset mid-line restarts cleanly at the next in_vsync.
- in_href low mid-line: the window does not shift and the col counter clears.

## Configuration
- ISP_BNR_EDGE_CLAMP_EN:
  - Defined: window taps whose source lies outside the frame are treated as excluded and replaced by c. This affects taps with row < 0 or col < 0, relative to centre rows/cols 0 and 1.
  - Undefined: those taps use whatever the line buffer and registers hold (stale data from the previous line or frame). This saves the comparators on the edge taps.

## Structure
- Package isp_bnr_pkg holds:
  - DLY_CLK;
  - weight constants for R/B and G;
  - bayer encoding localparams;
  - the strength clamp value 16.
- Sub-module isp_bnr_linebuf holds 4 lines × WIDTH × BITS, shifted on in_href, and exposes taps 0..3.

## Test plan
All scenarios use BITS=8, WIDTH=16, HEIGHT=8.
- Flat field 100, thresh 255, strength 16 → every valid output 100; positions with row<2 or col<2 output 0.
- R pixel 200 in a flat field of 100, bayer 0, thresh 255, strength 16 → that pixel outputs 125; the R pixel two columns right outputs 112.
- Same stimulus with thresh 50 → hot pixel outputs 200; the neighbouring R pixel outputs 100.
- Same stimulus with thresh 255, strength 8 → hot pixel outputs 162 (floor of −37.5 is −38).
- Write strength 0 mid-frame → the current frame is unchanged; the next frame's output equals its input delayed.
- rst_n low for 1 cycle mid-line → all outputs 0 on the next cycle; after the next vsync the flat-field check passes again.
